// File: rtl/free_list.sv
// free_list: physical-register free list for the 3-wide rename stage.
// Circular buffer of unmapped physical tags with compacted 3-wide allocate/free
// and a single-cycle checkpoint recovery.
// Optional feature macro: FL_FREE_BYPASS_EN (same-cycle reuse of retiring tags).

`ifndef SYS_PHYS_REG_ADDR_WIDTH
`define SYS_PHYS_REG_ADDR_WIDTH 6
`endif

module free_list #(
    parameter int unsigned PR_W     = `SYS_PHYS_REG_ADDR_WIDTH,
    parameter int unsigned FL_DEPTH = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [2:0]        dispatch_req,
    output logic [3*PR_W-1:0] dispatch_pr_alloc_tags,
    output logic [1:0]        fl_avail,
    input  logic [2:0]        retire_free_vld,
    input  logic [3*PR_W-1:0] retire_free_tags,
    input  logic              fch_rec_enable,
    output logic              fl_err
);
    localparam int unsigned IDX_W = $clog2(FL_DEPTH);
    localparam int unsigned CNT_W = IDX_W + 1;
    localparam int unsigned SUM_W = IDX_W + 2;
    localparam int unsigned BASE  = (1 << PR_W) - FL_DEPTH;

    logic [PR_W-1:0]  fl_buf_q [FL_DEPTH];
    logic [IDX_W-1:0] head_q, head_d;
    logic [IDX_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             err_q, err_d;

    logic [1:0]       req_pre  [3];
    logic [1:0]       free_pre [3];
    logic [1:0]       nalloc, nfree;
    logic [PR_W-1:0]  free_tag [3];
    logic [SUM_W-1:0] avail_src, next_cnt;
    logic [1:0]       avail_c;
    logic             over_req, overflow, alloc_ok;
    logic [1:0]       nalloc_eff, nfree_eff;
    logic [2:0]       wr_en;
    logic [IDX_W-1:0] wr_idx [3];
`ifdef FL_FREE_BYPASS_EN
    logic [PR_W-1:0]  free_cmp [3];
    logic [1:0]       byp_n;
`endif

    // Prefix popcounts give each slot its compacted position; unpack free tags.
    always_comb begin
        req_pre[0]  = 2'd0;
        req_pre[1]  = 2'(dispatch_req[0]);
        req_pre[2]  = 2'(dispatch_req[0]) + 2'(dispatch_req[1]);
        nalloc      = req_pre[2] + 2'(dispatch_req[2]);
        free_pre[0] = 2'd0;
        free_pre[1] = 2'(retire_free_vld[0]);
        free_pre[2] = 2'(retire_free_vld[0]) + 2'(retire_free_vld[1]);
        nfree       = free_pre[2] + 2'(retire_free_vld[2]);
        for (int k = 0; k < 3; k++) begin
            free_tag[k] = retire_free_tags[k*PR_W +: PR_W];
        end
    end

    // Availability, error detection, tag selection and next-state computation.
    always_comb begin
        dispatch_pr_alloc_tags = '0;
`ifdef FL_FREE_BYPASS_EN
        avail_src = SUM_W'(count_q) + SUM_W'(nfree);
`else
        avail_src = SUM_W'(count_q);
`endif
        if (fch_rec_enable) begin
            avail_c = 2'd0;
        end else if (avail_src >= SUM_W'(3)) begin
            avail_c = 2'd3;
        end else begin
            avail_c = avail_src[1:0];
        end
        fl_avail = avail_c;

        // Dispatch is ignored during recovery, so it cannot over-request then.
        over_req   = !fch_rec_enable && (nalloc > avail_c);
        alloc_ok   = !fch_rec_enable && !over_req;
        nalloc_eff = alloc_ok ? nalloc : 2'd0;
        next_cnt   = SUM_W'(count_q) + SUM_W'(nfree) - SUM_W'(nalloc_eff);
        overflow   = next_cnt > SUM_W'(FL_DEPTH);
        nfree_eff  = overflow ? 2'd0 : nfree;

`ifdef FL_FREE_BYPASS_EN
        // Slots beyond the stored count consume the oldest incoming frees directly.
        for (int k = 0; k < 3; k++) begin
            free_cmp[k] = '0;
        end
        for (int k = 0; k < 3; k++) begin
            if (retire_free_vld[k]) begin
                free_cmp[free_pre[k]] = free_tag[k];
            end
        end
        if (SUM_W'(nalloc_eff) > SUM_W'(count_q)) begin
            byp_n = 2'(SUM_W'(nalloc_eff) - SUM_W'(count_q));
        end else begin
            byp_n = 2'd0;
        end
`endif

        for (int k = 0; k < 3; k++) begin
            wr_idx[k] = tail_q + IDX_W'(free_pre[k]);
`ifdef FL_FREE_BYPASS_EN
            wr_en[k]  = retire_free_vld[k] && !overflow && (free_pre[k] >= byp_n);
`else
            wr_en[k]  = retire_free_vld[k] && !overflow;
`endif
            if (alloc_ok && dispatch_req[k]) begin
                dispatch_pr_alloc_tags[k*PR_W +: PR_W] = fl_buf_q[head_q + IDX_W'(req_pre[k])];
`ifdef FL_FREE_BYPASS_EN
                if (SUM_W'(req_pre[k]) >= SUM_W'(count_q)) begin
                    dispatch_pr_alloc_tags[k*PR_W +: PR_W] =
                        free_cmp[2'(SUM_W'(req_pre[k]) - SUM_W'(count_q))];
                end
`endif
            end
        end

        // Bypassed tags are skipped by tail and head alike, keeping [head,tail) consistent.
        tail_d  = tail_q + IDX_W'(nfree_eff);
        head_d  = fch_rec_enable ? tail_d : head_q + IDX_W'(nalloc_eff);
        count_d = fch_rec_enable ? CNT_W'(FL_DEPTH)
                                 : CNT_W'(SUM_W'(count_q) + SUM_W'(nfree_eff) - SUM_W'(nalloc_eff));
        err_d   = err_q | over_req | overflow;
    end

    assign fl_err = err_q;

    // State and buffer registers; reset loads the non-architectural tags in order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < FL_DEPTH; i++) begin
                fl_buf_q[i] <= PR_W'(BASE + i);
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= CNT_W'(FL_DEPTH);
            err_q   <= 1'b0;
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (wr_en[k]) begin
                    fl_buf_q[wr_idx[k]] <= free_tag[k];
                end
            end
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_free_list.sv
// tb_free_list: directed vectors for free_list with a queue-based scoreboard.
module tb_free_list;
    localparam int unsigned PR_W = 6;

    logic              clk;
    logic              rst_n;
    logic [2:0]        dispatch_req;
    logic [3*PR_W-1:0] dispatch_pr_alloc_tags;
    logic [1:0]        fl_avail;
    logic [2:0]        retire_free_vld;
    logic [3*PR_W-1:0] retire_free_tags;
    logic              fch_rec_enable;
    logic              fl_err;

    typedef struct {
        string             name;
        logic [1:0]        av;
        logic [3*PR_W-1:0] tags;
        logic              er;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    free_list dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .dispatch_req           (dispatch_req),
        .dispatch_pr_alloc_tags (dispatch_pr_alloc_tags),
        .fl_avail               (fl_avail),
        .retire_free_vld        (retire_free_vld),
        .retire_free_tags       (retire_free_tags),
        .fch_rec_enable         (fch_rec_enable),
        .fl_err                 (fl_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3*PR_W-1:0] t3(input int a, input int b, input int c);
        t3 = {PR_W'(c), PR_W'(b), PR_W'(a)};
    endfunction

    // Drive one cycle of stimulus just after the edge and queue its expected response.
    task automatic step(input string name, input logic rst, input logic [2:0] req,
                        input logic [2:0] fv, input logic [3*PR_W-1:0] ft, input logic rec,
                        input logic [1:0] av, input logic [3*PR_W-1:0] tags, input logic er);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n            = rst;
        dispatch_req     = req;
        retire_free_vld  = fv;
        retire_free_tags = ft;
        fch_rec_enable   = rec;
        e.name = name;
        e.av   = av;
        e.tags = tags;
        e.er   = er;
        exp_q.push_back(e);
    endtask

    // Monitor: outputs are valid every cycle; compare mid-cycle against the queue head.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            if (fl_avail !== e.av) begin
                failures++;
                $display("FAIL %s avail: got %0d exp %0d", e.name, fl_avail, e.av);
            end
            checks++;
            if (dispatch_pr_alloc_tags !== e.tags) begin
                failures++;
                $display("FAIL %s tags: got {%0d,%0d,%0d} exp {%0d,%0d,%0d}", e.name,
                         dispatch_pr_alloc_tags[0 +: PR_W], dispatch_pr_alloc_tags[PR_W +: PR_W],
                         dispatch_pr_alloc_tags[2*PR_W +: PR_W],
                         e.tags[0 +: PR_W], e.tags[PR_W +: PR_W], e.tags[2*PR_W +: PR_W]);
            end
            checks++;
            if (fl_err !== e.er) begin
                failures++;
                $display("FAIL %s err: got %0d exp %0d", e.name, fl_err, e.er);
            end
        end
    end

    initial begin
        logic [1:0] av_free;
        rst_n            = 1'b0;
        dispatch_req     = '0;
        retire_free_vld  = '0;
        retire_free_tags = '0;
        fch_rec_enable   = 1'b0;

        step("reset",    1, 3'b000, 3'b000, '0, 0, 2'd3, t3(0, 0, 0), 0);
        step("alloc3",   1, 3'b111, 3'b000, '0, 0, 2'd3, t3(32, 33, 34), 0);
        step("sparse",   1, 3'b101, 3'b000, '0, 0, 2'd3, t3(35, 0, 36), 0);
        for (int i = 0; i < 9; i++) begin
            step("drain", 1, 3'b111, 3'b000, '0, 0, 2'd3, t3(37+3*i, 38+3*i, 39+3*i), 0);
        end
        step("empty",    1, 3'b000, 3'b000, '0, 0, 2'd0, t3(0, 0, 0), 0);
        step("overreq",  1, 3'b001, 3'b000, '0, 0, 2'd0, t3(0, 0, 0), 0);
`ifdef FL_FREE_BYPASS_EN
        av_free = 2'd2;
`else
        av_free = 2'd0;
`endif
        step("freepair", 1, 3'b000, 3'b011, t3(40, 41, 0), 0, av_free, t3(0, 0, 0), 1);
        step("reuse",    1, 3'b011, 3'b000, '0, 0, 2'd2, t3(40, 41, 0), 1);
        step("async_rst", 0, 3'b111, 3'b000, '0, 0, 2'd3, t3(32, 33, 34), 0);
        step("post_rst", 1, 3'b111, 3'b000, '0, 0, 2'd3, t3(32, 33, 34), 0);
        step("alloc_b",  1, 3'b111, 3'b000, '0, 0, 2'd3, t3(35, 36, 37), 0);
        step("recover",  1, 3'b111, 3'b011, t3(5, 6, 0), 1, 2'd0, t3(0, 0, 0), 0);
        step("rec_next", 1, 3'b111, 3'b000, '0, 0, 2'd3, t3(34, 35, 36), 0);
        step("rec_one",  1, 3'b001, 3'b000, '0, 0, 2'd3, t3(37, 0, 0), 0);
        for (int i = 0; i < 8; i++) begin
            step("walk", 1, 3'b111, 3'b000, '0, 0, 2'd3, t3(38+3*i, 39+3*i, 40+3*i), 0);
        end
        step("wrap",     1, 3'b111, 3'b000, '0, 0, 2'd3, t3(62, 63, 5), 0);
        step("last",     1, 3'b001, 3'b000, '0, 0, 2'd1, t3(6, 0, 0), 0);
        step("rst2",     0, 3'b000, 3'b000, '0, 0, 2'd3, t3(0, 0, 0), 0);
        step("overflow", 1, 3'b000, 3'b001, t3(9, 0, 0), 0, 2'd3, t3(0, 0, 0), 0);
        step("post_ovf", 1, 3'b111, 3'b000, '0, 0, 2'd3, t3(32, 33, 34), 1);

        @(posedge clk);
        @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain_queue: got %0d pending exp 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout exp completion");
        $fatal(1, "watchdog");
    end

endmodule
